// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
//
// Shares a single FIFO write port (winc/wdata/wfull) among NREQ requesters.
// Ownership is granted round-robin in bursts of at most BURST_LEN words.
// A full FIFO stalls the owner without releasing it.
//
// Ports:
//   wclk      write-domain clock, all state on the rising edge
//   wrst_n    asynchronous active-low reset
//   req       per-requester request, held while a word is offered
//   req_data  packed words, requester k at [k*DSIZE +: DSIZE]
//   ack       one-hot, high when the owner's word is written this cycle
//   gnt       registered one-hot owner, zero when idle
//   winc      FIFO write enable
//   wdata     FIFO write data (owner's word, zero when idle)
//   wfull     FIFO full flag
//   busy      registered, high while a grant is held
module fifo_wr_arbiter #(
  parameter int DSIZE     = 8,
  parameter int NREQ      = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                    wclk,
  input  logic                    wrst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  output logic [NREQ-1:0]         ack,
  output logic [NREQ-1:0]         gnt,
  output logic                    winc,
  output logic [DSIZE-1:0]        wdata,
  input  logic                    wfull,
  output logic                    busy
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int IW = $clog2(NREQ);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   owner, owner_n;
  logic [IW-1:0]   last, last_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            hold, hold_n;
  logic [NREQ-1:0] gnt_n;
  logic            busy_n;

  logic [IW-1:0]   arb_base;
  logic [IW-1:0]   arb_idx;
  logic [IW-1:0]   cand;
  logic            arb_found;

  logic            owner_req;
  logic            xfer;
  logic            burst_done;
  logic            rel;

  // Round-robin search starting just after the base; the base itself is
  // visited last, so it only wins when nobody else is requesting.
  always_comb begin
    arb_base  = (state == BURST) ? owner : last;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(arb_base) + i) % NREQ);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // A re-grant to the same owner spends one cycle in hold, which gives the
  // one-word gap between back-to-back bursts of a lone requester.
  always_comb begin
    owner_req  = |(req & gnt);
    xfer       = busy & ~hold & owner_req & ~wfull;
    burst_done = xfer && (cnt == CW'(BURST_LEN - 1));
    rel        = burst_done || !owner_req;
  end

  // State register
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state <= IDLE;
      owner <= '0;
      last  <= IW'(NREQ - 1);
      cnt   <= '0;
      hold  <= 1'b0;
      gnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last  <= last_n;
      cnt   <= cnt_n;
      hold  <= hold_n;
      gnt   <= gnt_n;
      busy  <= busy_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last;
    cnt_n   = cnt;
    hold_n  = 1'b0;
    case (state)
      IDLE: begin
        if (arb_found) begin
          state_n = BURST;
          owner_n = arb_idx;
          cnt_n   = '0;
        end
      end
      BURST: begin
        if (xfer) begin
          cnt_n = cnt + CW'(1);
        end
        if (rel) begin
          last_n = owner;
          cnt_n  = '0;
          if (!arb_found) begin
            state_n = IDLE;
          end else begin
            owner_n = arb_idx;
            hold_n  = (arb_idx == owner);
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    gnt_n  = (state_n == BURST) ? (NREQ'(1) << owner_n) : '0;
    busy_n = (state_n == BURST);
  end

  // Output logic; gnt is one-hot or zero, so the AND-OR mux yields zero idle.
  always_comb begin
    winc  = xfer;
    ack   = xfer ? gnt : '0;
    wdata = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt[k]) begin
        wdata = wdata | req_data[k*DSIZE +: DSIZE];
      end
    end
  end

endmodule
